// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one multi-cycle FP add/sub unit between
// NUM_REQ requesters. One operation in flight; operands are latched at grant,
// the adder gets a single clk_en pulse, and the result (or a qNaN on timeout)
// is returned to the owner before the priority pointer advances.
module fp_add_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_add_sub,
  input  logic [NUM_REQ*DATA_W-1:0] req_dataa,
  input  logic [NUM_REQ*DATA_W-1:0] req_datab,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_result,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      add_clk_en,
  output logic                      add_add_sub,
  output logic [DATA_W-1:0]         add_dataa,
  output logic [DATA_W-1:0]         add_datab,
  input  logic [DATA_W-1:0]         add_result,
  input  logic                      add_done
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] QNan = DATA_W'(32'h7FC0_0000);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]     last_grant_q, last_grant_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_result_q, resp_result_d;
  logic                timeout_err_q, timeout_err_d;
  logic                add_clk_en_q, add_clk_en_d;
  logic                add_add_sub_q, add_add_sub_d;
  logic [DATA_W-1:0]   add_dataa_q, add_dataa_d;
  logic [DATA_W-1:0]   add_datab_q, add_datab_d;

  logic                win_valid;
  logic [IdxW-1:0]     win_idx;
  logic [IdxW-1:0]     cand;

  // Round-robin pick: first set req bit searching upward from last_grant+1, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_grant_q) + k) % NUM_REQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    ack_d         = '0;
    resp_valid_d  = '0;
    resp_result_d = resp_result_q;
    timeout_err_d = timeout_err_q;
    add_clk_en_d  = 1'b0;
    add_add_sub_d = add_add_sub_q;
    add_dataa_d   = add_dataa_q;
    add_datab_d   = add_datab_q;

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          grant_d       = win_idx;
          add_dataa_d   = req_dataa[win_idx*DATA_W +: DATA_W];
          add_datab_d   = req_datab[win_idx*DATA_W +: DATA_W];
          add_add_sub_d = req_add_sub[win_idx];
          ack_d         = NUM_REQ'(1) << win_idx;
          // clk_en is high for the single cycle spent in StIssue.
          add_clk_en_d  = 1'b1;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (add_done) begin
          resp_result_d = add_result;
          resp_valid_d  = NUM_REQ'(1) << grant_q;
          state_d       = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // TIMEOUT full cycles in StWait without done: abandon with a quiet NaN.
          timeout_err_d = 1'b1;
          resp_result_d = QNan;
          resp_valid_d  = NUM_REQ'(1) << grant_q;
          state_d       = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; async reset abandons any in-flight operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      last_grant_q  <= IdxW'(NUM_REQ - 1);
      cnt_q         <= '0;
      ack_q         <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      timeout_err_q <= 1'b0;
      add_clk_en_q  <= 1'b0;
      add_add_sub_q <= 1'b1;
      add_dataa_q   <= '0;
      add_datab_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      timeout_err_q <= timeout_err_d;
      add_clk_en_q  <= add_clk_en_d;
      add_add_sub_q <= add_add_sub_d;
      add_dataa_q   <= add_dataa_d;
      add_datab_q   <= add_datab_d;
    end
  end

  assign ack         = ack_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_err_q;
  assign add_clk_en  = add_clk_en_q;
  assign add_add_sub = add_add_sub_q;
  assign add_dataa   = add_dataa_q;
  assign add_datab   = add_datab_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model (round-robin pick, fixed latencies, scoreboarded results).
module tb_fp_add_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned LAT     = 9;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_add_sub;
  logic [NUM_REQ*DATA_W-1:0] req_dataa;
  logic [NUM_REQ*DATA_W-1:0] req_datab;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_result;
  logic                      busy;
  logic                      timeout_err;
  logic                      add_clk_en;
  logic                      add_add_sub;
  logic [DATA_W-1:0]         add_dataa;
  logic [DATA_W-1:0]         add_datab;
  logic [DATA_W-1:0]         add_result = '0;
  logic                      add_done = 1'b0;

  always #5 clock = ~clock;

  fp_add_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .req_add_sub (req_add_sub),
    .req_dataa   (req_dataa),
    .req_datab   (req_datab),
    .ack         (ack),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .busy        (busy),
    .timeout_err (timeout_err),
    .add_clk_en  (add_clk_en),
    .add_add_sub (add_add_sub),
    .add_dataa   (add_dataa),
    .add_datab   (add_datab),
    .add_result  (add_result),
    .add_done    (add_done)
  );

  // Single-precision <-> real conversion for normal numbers and zero.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b,
                                        input logic op);
    real r;
    r = op ? (sp2r(a) + sp2r(b)) : (sp2r(a) - sp2r(b));
    return r2sp(r);
  endfunction

  function automatic logic [31:0] rnd_fp();
    real r;
    r = real'($urandom_range(0, 2000));
    if ($urandom_range(0, 1) == 1) r = -r;
    return r2sp(r);
  endfunction

  // Adder model: done pulses LAT edges after clk_en is sampled, unless dead.
  int unsigned adr_cnt = 0;
  logic [31:0] adr_res = '0;
  logic        adder_dead = 1'b0;

  always @(posedge clock) begin
    add_done <= 1'b0;
    if (adr_cnt != 0) begin
      if (adr_cnt == 1) begin
        add_done   <= 1'b1;
        add_result <= adr_res;
      end
      adr_cnt <= adr_cnt - 1;
    end
    if (add_clk_en && !adder_dead) begin
      adr_cnt <= LAT;
      adr_res <= fp_op(add_dataa, add_datab, add_add_sub);
    end
  end

  // Reference model state (edge-indexed transaction view).
  int                 checks = 0;
  int                 failures = 0;
  int                 t = 0;
  int                 m_last, m_idle_from, m_grant_edge, m_resp_edge, m_owner;
  logic [31:0]        m_a, m_b, m_exp_res, m_hold;
  logic               m_op, m_dead_op, m_terr;
  logic [NUM_REQ-1:0] m_ack, m_rv;
  logic               hold_all = 1'b0;
  logic               rand_en = 1'b0;

  // Observed-traffic bookkeeping for the directed checks.
  int grant_q[$];
  int last_dut_ack = 0;
  int ack1_cnt = 0;
  int rv1_cnt = 0;
  int rv_cnt = 0;
  int clk_en_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, t);
    end
  endtask

  function automatic logic m_busy();
    return (t >= m_grant_edge) && (t <= m_resp_edge);
  endfunction

  task automatic mdl_reset();
    m_last       = NUM_REQ - 1;
    m_idle_from  = t + 1;
    m_grant_edge = -100;
    m_resp_edge  = -100;
    m_hold       = '0;
    m_terr       = 1'b0;
    m_ack        = '0;
    m_rv         = '0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic mdl_edge();
    int   c;
    logic found;
    t++;
    m_ack = '0;
    m_rv  = '0;
    found = 1'b0;
    if (t == m_resp_edge) begin
      m_rv[m_owner] = 1'b1;
      m_hold        = m_dead_op ? QNAN : m_exp_res;
      if (m_dead_op) m_terr = 1'b1;
      m_last      = m_owner;
      m_idle_from = t + 2;
    end else if (t >= m_idle_from && req != '0) begin
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
        c = (m_last + k) % int'(NUM_REQ);
        if (req[c] && !found) begin
          found   = 1'b1;
          m_owner = c;
        end
      end
      m_a          = req_dataa[m_owner*DATA_W +: DATA_W];
      m_b          = req_datab[m_owner*DATA_W +: DATA_W];
      m_op         = req_add_sub[m_owner];
      m_exp_res    = fp_op(m_a, m_b, m_op);
      m_dead_op    = adder_dead;
      m_grant_edge = t;
      m_resp_edge  = adder_dead ? t + 1 + int'(TIMEOUT) : t + 2 + int'(LAT);
      m_idle_from  = 1 << 30;
      m_ack[m_owner] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check_eq("ack", 32'(ack), 32'(m_ack));
    check_eq("resp_valid", 32'(resp_valid), 32'(m_rv));
    check_eq("resp_result", resp_result, m_hold);
    check_eq("busy", 32'(busy), 32'(m_busy()));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_terr));
    check_eq("add_clk_en", 32'(add_clk_en), 32'(t == m_grant_edge));
    if (m_busy()) begin
      check_eq("add_dataa", add_dataa, m_a);
      check_eq("add_datab", add_datab, m_b);
      check_eq("add_add_sub", 32'(add_add_sub), 32'(m_op));
    end
  endtask

  task automatic new_op(input int i);
    req_dataa[i*DATA_W +: DATA_W] = rnd_fp();
    req_datab[i*DATA_W +: DATA_W] = rnd_fp();
    req_add_sub[i] = ($urandom_range(0, 1) == 1);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic op);
    req_dataa[i*DATA_W +: DATA_W] = a;
    req_datab[i*DATA_W +: DATA_W] = b;
    req_add_sub[i] = op;
  endtask

  // Requesters drop (or renew) on ack and randomly raise new work when enabled.
  task automatic update_reqs();
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (m_ack[i]) begin
        if (hold_all) new_op(i);
        else req[i] = 1'b0;
      end else if (rand_en && !req[i] && $urandom_range(0, 3) == 0) begin
        new_op(i);
        req[i] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    mdl_edge();
    @(negedge clock);
    check_outputs();
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ack[i]) begin
        grant_q.push_back(i);
        last_dut_ack = i;
        if (i == 1) ack1_cnt++;
      end
    end
    if (resp_valid != '0) begin
      rv_cnt++;
      check_eq("resp_owner", 32'(resp_valid), 32'(1) << last_dut_ack);
    end
    if (resp_valid[1]) rv1_cnt++;
    if (add_clk_en) clk_en_cnt++;
    update_reqs();
  endtask

  task automatic run_until_resp(input string tag, input int bound);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    while (n < bound && !got) begin
      cycle();
      n++;
      if (resp_valid != '0) got = 1'b1;
    end
    check_eq({tag, "_resp_seen"}, 32'(got), 32'd1);
  endtask

  task automatic run_until_ack(input string tag, input int bound);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    while (n < bound && !got) begin
      cycle();
      n++;
      if (ack != '0) got = 1'b1;
    end
    check_eq({tag, "_ack_seen"}, 32'(got), 32'd1);
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (n < bound && (req != '0 || m_busy())) begin
      cycle();
      n++;
    end
    check_eq({tag, "_drained"}, 32'(req != '0 || m_busy()), 32'd0);
    cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    mdl_reset();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ack"}, 32'(ack), 32'd0);
    check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_resp_result"}, resp_result, 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check_eq({tag, "_clk_en"}, 32'(add_clk_en), 32'd0);
    check_eq({tag, "_add_sub"}, 32'(add_add_sub), 32'd1);
    check_eq({tag, "_dataa"}, add_dataa, 32'd0);
    check_eq({tag, "_datab"}, add_datab, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got no summary expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_req;
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};
    reset_n     = 1'b0;
    req         = '0;
    req_add_sub = '0;
    req_dataa   = '0;
    req_datab   = '0;
    repeat (3) @(negedge clock);
    check_reset_values("rst");
    reset_n = 1'b1;
    mdl_reset();
    cycle();

    // Single add on requester 0: 1.0 + 2.0.
    clk_en_cnt = 0;
    set_op(0, 32'h3F80_0000, 32'h4000_0000, 1'b1);
    req[0] = 1'b1;
    t_req  = t;
    run_until_resp("add", 40);
    check_eq("add_latency", 32'(t - t_req), 32'd12);
    check_eq("add_result", resp_result, 32'h4040_0000);
    check_eq("add_rv", 32'(resp_valid), 32'h1);
    check_eq("add_clk_en_pulses", 32'(clk_en_cnt), 32'd1);
    run_until_idle("add", 10);

    // Subtract on requester 2: 3.0 - 1.0.
    set_op(2, 32'h4040_0000, 32'h3F80_0000, 1'b0);
    req[2] = 1'b1;
    run_until_resp("sub", 40);
    check_eq("sub_result", resp_result, 32'h4000_0000);
    check_eq("sub_rv", 32'(resp_valid), 32'h4);
    check_eq("sub_op_held", 32'(add_add_sub), 32'd0);
    run_until_idle("sub", 10);

    // All requesters held continuously from reset.
    do_reset();
    grant_q.delete();
    hold_all = 1'b1;
    for (int i = 0; i < int'(NUM_REQ); i++) new_op(i);
    req = '1;
    begin
      int n;
      n = 0;
      while (n < 120 && grant_q.size() < 6) begin
        cycle();
        n++;
      end
    end
    hold_all = 1'b0;
    req      = '0;
    run_until_idle("rr", 40);
    check_eq("rr_grants", 32'(grant_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_q.size()) check_eq("rr_order", 32'(grant_q[i]), 32'(exp_order[i]));
    end

    // Adder never answers: timeout, qNaN, sticky error.
    adder_dead = 1'b1;
    set_op(0, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    req[0] = 1'b1;
    t_req  = t;
    run_until_resp("tmo", 60);
    check_eq("tmo_latency", 32'(t - t_req), 32'(2 + TIMEOUT));
    check_eq("tmo_result", resp_result, QNAN);
    check_eq("tmo_err", 32'(timeout_err), 32'd1);
    run_until_idle("tmo", 10);
    check_eq("tmo_idle", 32'(busy), 32'd0);
    adder_dead = 1'b0;
    set_op(1, 32'h4000_0000, 32'h4000_0000, 1'b1);
    req[1] = 1'b1;
    run_until_resp("post_tmo", 40);
    check_eq("post_tmo_result", resp_result, 32'h4080_0000);
    check_eq("tmo_sticky", 32'(timeout_err), 32'd1);
    run_until_idle("post_tmo", 10);

    // Async reset in the middle of WAIT; late done must be ignored.
    set_op(2, 32'h4000_0000, 32'h3F80_0000, 1'b1);
    req[2] = 1'b1;
    run_until_ack("mid", 10);
    repeat (4) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    req     = '0;
    mdl_reset();
    rv_cnt = 0;
    repeat (15) cycle();
    check_eq("late_done_ignored", 32'(rv_cnt), 32'd0);
    for (int i = 0; i < int'(NUM_REQ); i++) new_op(i);
    req = '1;
    run_until_ack("after_rst", 10);
    check_eq("first_grant_after_rst", 32'(ack), 32'h1);
    req = '0;
    run_until_idle("after_rst", 40);

    // Requester 1 pulses req for one cycle while requester 3 is being served.
    ack1_cnt = 0;
    rv1_cnt  = 0;
    set_op(3, 32'h4040_0000, 32'h4040_0000, 1'b0);
    req[3] = 1'b1;
    run_until_ack("pulse", 10);
    set_op(1, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    req[1] = 1'b1;
    cycle();
    req[1] = 1'b0;
    run_until_resp("pulse", 40);
    check_eq("pulse_result", resp_result, 32'd0);
    run_until_idle("pulse", 10);
    repeat (5) cycle();
    check_eq("pulse_no_ack1", 32'(ack1_cnt), 32'd0);
    check_eq("pulse_no_rv1", 32'(rv1_cnt), 32'd0);

    // Random traffic with occasional dead-adder operations.
    rand_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      cycle();
      if (!m_busy() && m_ack == '0 && $urandom_range(0, 40) == 0) adder_dead = ~adder_dead;
    end
    rand_en = 1'b0;
    run_until_idle("rand", 300);
    adder_dead = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
